// File: rtl/unidade_controle_multiciclo.sv
// Multi-cycle control unit for the MIPS-subset datapath.
// Moore FSM sequencing fetch/decode/execute/memory/write-back, plus the
// ALU decoder producing ULA_control from opcode/funct.
// Optional feature macro: ADDI_EN (adds addi support via ADDIEXEC/ADDIWB).
module unidade_controle_multiciclo (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       Zero,
    output logic       pc_en,
    output logic       i_or_d,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       ula_src_a,
    output logic [1:0] ula_src_b,
    output logic [1:0] pc_src,
    output logic [2:0] ULA_control,
    output logic [3:0] estado,
    output logic       opcode_invalido
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

`ifdef ADDI_EN
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEXEC = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11
    } state_t;
`else
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        JUMP     = 4'd11
    } state_t;
`endif

    state_t     state;
    state_t     next_state;
    logic       pc_write;
    logic       branch;
    logic [2:0] funct_ctrl;
    logic       funct_ok;

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset)
            state <= FETCH;
        else
            state <= next_state;
    end

    // ALU decoder for R-type funct codes
    always_comb begin
        funct_ctrl = 3'b010;
        funct_ok   = 1'b1;
        case (funct)
            6'b100000: funct_ctrl = 3'b010;
            6'b100010: funct_ctrl = 3'b110;
            6'b100100: funct_ctrl = 3'b000;
            6'b100101: funct_ctrl = 3'b001;
            6'b101010: funct_ctrl = 3'b111;
            6'b100111: funct_ctrl = 3'b100;
            default:   funct_ok   = 1'b0;
        endcase
    end

    // Next-state logic and Moore output decode; reset overrides everything
    always_comb begin
        next_state      = FETCH;
        pc_write        = 1'b0;
        branch          = 1'b0;
        i_or_d          = 1'b0;
        mem_write       = 1'b0;
        ir_write        = 1'b0;
        reg_dst         = 1'b0;
        mem_to_reg      = 1'b0;
        reg_write       = 1'b0;
        ula_src_a       = 1'b0;
        ula_src_b       = 2'b00;
        pc_src          = 2'b00;
        ULA_control     = 3'b010;
        opcode_invalido = 1'b0;
        estado          = state;

        case (state)
            FETCH: begin
                ir_write   = 1'b1;
                pc_write   = 1'b1;
                ula_src_b  = 2'b01;
                next_state = DECODE;
            end
            DECODE: begin
                ula_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_RTYPE:     next_state = EXECUTE;
                    OP_BEQ:       next_state = BRANCH;
`ifdef ADDI_EN
                    OP_ADDI:      next_state = ADDIEXEC;
`endif
                    OP_J:         next_state = JUMP;
                    default: begin
                        opcode_invalido = 1'b1;
                        next_state      = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                ula_src_a  = 1'b1;
                ula_src_b  = 2'b10;
                next_state = (opcode == OP_SW) ? MEMWR : MEMREAD;
            end
            MEMREAD: begin
                i_or_d     = 1'b1;
                next_state = MEMWB;
            end
            MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            MEMWR: begin
                i_or_d    = 1'b1;
                mem_write = 1'b1;
            end
            EXECUTE: begin
                ula_src_a   = 1'b1;
                ula_src_b   = 2'b00;
                ULA_control = funct_ctrl;
                if (funct_ok) begin
                    next_state = ALUWB;
                end else begin
                    opcode_invalido = 1'b1;
                    next_state      = FETCH;
                end
            end
            ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            BRANCH: begin
                ula_src_a   = 1'b1;
                ula_src_b   = 2'b00;
                ULA_control = 3'b110;
                pc_src      = 2'b01;
                branch      = 1'b1;
            end
`ifdef ADDI_EN
            ADDIEXEC: begin
                ula_src_a  = 1'b1;
                ula_src_b  = 2'b10;
                next_state = ADDIWB;
            end
            ADDIWB: begin
                reg_write = 1'b1;
            end
`endif
            JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
            default: next_state = FETCH;
        endcase

        if (reset) begin
            next_state      = FETCH;
            pc_write        = 1'b0;
            branch          = 1'b0;
            i_or_d          = 1'b0;
            mem_write       = 1'b0;
            ir_write        = 1'b0;
            reg_dst         = 1'b0;
            mem_to_reg      = 1'b0;
            reg_write       = 1'b0;
            ula_src_a       = 1'b0;
            ula_src_b       = 2'b00;
            pc_src          = 2'b00;
            ULA_control     = 3'b010;
            opcode_invalido = 1'b0;
            estado          = '0;
        end
    end

    // PC load enable: unconditional write or taken branch
    always_comb begin
        pc_en = pc_write | (branch & Zero);
    end

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Self-checking bench for unidade_controle_multiciclo.
// Per-cycle vectors carry inputs and the expected state; the remaining
// outputs come from a reference decode of that expected state.
module tb_unidade_controle_multiciclo;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       Zero = 1'b0;
    logic       pc_en, i_or_d, mem_write, ir_write, reg_dst, mem_to_reg;
    logic       reg_write, ula_src_a, opcode_invalido;
    logic [1:0] ula_src_b, pc_src;
    logic [2:0] ULA_control;
    logic [3:0] estado;

    always #5 clk = ~clk;

    unidade_controle_multiciclo dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .Zero(Zero),
        .pc_en(pc_en), .i_or_d(i_or_d), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .ula_src_a(ula_src_a), .ula_src_b(ula_src_b), .pc_src(pc_src),
        .ULA_control(ULA_control), .estado(estado), .opcode_invalido(opcode_invalido)
    );

    // {estado, pc_en, i_or_d, mem_write, ir_write, reg_dst, mem_to_reg,
    //  reg_write, ula_src_a, ula_src_b, pc_src, ULA_control, opcode_invalido}
    logic [19:0] act;
    assign act = {estado, pc_en, i_or_d, mem_write, ir_write, reg_dst, mem_to_reg,
                  reg_write, ula_src_a, ula_src_b, pc_src, ULA_control, opcode_invalido};

    typedef struct {
        logic       rst;
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        logic [3:0] st;
        string      name;
    } vec_t;

    vec_t        tbl[$];
    logic [19:0] sb[$];
    int          n_checks = 0;
    int          n_fail = 0;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010;
    localparam logic [5:0] BAD = 6'b111111;

    function automatic logic [19:0] exp_vec(input vec_t v);
        logic       pe, iod, mw, irw, rd, m2r, rw, sa, inv;
        logic [1:0] sb2, ps;
        logic [2:0] ctl;
        pe = 0; iod = 0; mw = 0; irw = 0; rd = 0; m2r = 0; rw = 0; sa = 0; inv = 0;
        sb2 = 2'b00; ps = 2'b00; ctl = 3'b010;
        if (!v.rst) begin
            case (v.st)
                4'd0: begin irw = 1; pe = 1; sb2 = 2'b01; end
                4'd1: begin
                    sb2 = 2'b11;
                    inv = !(v.op == LW || v.op == SW || v.op == RT || v.op == BEQ || v.op == J
`ifdef ADDI_EN
                            || v.op == ADDI
`endif
                           );
                end
                4'd2, 4'd9: begin sa = 1; sb2 = 2'b10; end
                4'd3: iod = 1;
                4'd4: begin m2r = 1; rw = 1; end
                4'd5: begin iod = 1; mw = 1; end
                4'd6: begin
                    sa = 1;
                    case (v.fn)
                        6'b100000: ctl = 3'b010;
                        6'b100010: ctl = 3'b110;
                        6'b100100: ctl = 3'b000;
                        6'b100101: ctl = 3'b001;
                        6'b101010: ctl = 3'b111;
                        6'b100111: ctl = 3'b100;
                        default:   inv = 1;
                    endcase
                end
                4'd7: begin rd = 1; rw = 1; end
                4'd8: begin sa = 1; ctl = 3'b110; ps = 2'b01; pe = v.z; end
                4'd10: rw = 1;
                4'd11: begin ps = 2'b10; pe = 1; end
                default: ;
            endcase
        end
        return {(v.rst ? 4'd0 : v.st), pe, iod, mw, irw, rd, m2r, rw, sa, sb2, ps, ctl, inv};
    endfunction

    task automatic add(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic [3:0] st, input string name);
        vec_t v;
        v.rst = rst; v.op = op; v.fn = fn; v.z = z; v.st = st; v.name = name;
        tbl.push_back(v);
    endtask

    // Drive one cycle of inputs, queue the expectation, compare mid-cycle
    task automatic apply(input vec_t v);
        logic [19:0] e;
        reset = v.rst; opcode = v.op; funct = v.fn; Zero = v.z;
        sb.push_back(exp_vec(v));
        @(negedge clk);
        e = sb.pop_front();
        n_checks++;
        if (act !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", v.name, act, e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                        input logic z, input logic [3:0] st, input string name);
        vec_t v;
        v.rst = rst; v.op = op; v.fn = fn; v.z = z; v.st = st; v.name = name;
        apply(v);
    endtask

    logic [5:0] fns[6];

    initial begin
        fns[0] = 6'b100000; fns[1] = 6'b100010; fns[2] = 6'b100100;
        fns[3] = 6'b100101; fns[4] = 6'b101010; fns[5] = 6'b100111;

        add(1, LW, 0, 0, 0, "reset0");
        add(1, LW, 0, 0, 0, "reset1");
        // lw; opcode changes after MEMADR must be ignored
        add(0, LW, 0, 0, 0, "lw_fetch");
        add(0, LW, 6'h3F, 0, 1, "lw_decode");
        add(0, LW, 0, 0, 2, "lw_memadr");
        add(0, BAD, 0, 0, 3, "lw_memread");
        add(0, SW, 0, 0, 4, "lw_memwb");
        for (int unsigned i = 0; i < 6; i++) begin
            add(0, RT, fns[i], 0, 0, "r_fetch");
            add(0, RT, 6'h00, 0, 1, "r_decode");
            add(0, RT, fns[i], 0, 6, "r_execute");
            add(0, RT, 6'h00, 0, 7, "r_aluwb");
        end
        add(0, RT, 6'h00, 0, 0, "badfn_fetch");
        add(0, RT, 6'h00, 0, 1, "badfn_decode");
        add(0, RT, 6'h00, 0, 6, "badfn_execute");
        add(0, BEQ, 0, 1, 0, "beq1_fetch");
        add(0, BEQ, 0, 1, 1, "beq1_decode");
        add(0, BEQ, 0, 1, 8, "beq1_branch");
        add(0, BEQ, 0, 0, 0, "beq0_fetch");
        add(0, BEQ, 0, 0, 1, "beq0_decode");
        add(0, BEQ, 0, 0, 8, "beq0_branch");
        add(0, J, 0, 0, 0, "j_fetch");
        add(0, J, 0, 0, 1, "j_decode");
        add(0, J, 0, 0, 11, "j_jump");
        add(0, BAD, 0, 0, 0, "badop_fetch");
        add(0, BAD, 0, 0, 1, "badop_decode");
        add(0, SW, 0, 0, 0, "sw_fetch");
        add(0, SW, 0, 0, 1, "sw_decode");
        add(0, SW, 0, 0, 2, "sw_memadr");
        add(0, SW, 0, 0, 5, "sw_memwr");
        add(0, ADDI, 0, 0, 0, "addi_fetch");
        add(0, ADDI, 0, 0, 1, "addi_decode");
`ifdef ADDI_EN
        add(0, ADDI, 0, 0, 9, "addi_exec");
        add(0, ADDI, 0, 0, 10, "addi_wb");
`endif
        add(0, LW, 0, 0, 0, "after_addi_fetch");

        foreach (tbl[i]) apply(tbl[i]);

        // sw aborted by reset during MEMADR: no write strobe, back to FETCH
        step(0, SW, 0, 0, 1, "abort_decode");
        step(1, SW, 0, 0, 0, "abort_memadr_reset");
        step(0, SW, 0, 0, 0, "abort_fetch");
        step(0, SW, 0, 0, 1, "abort_decode2");
        step(0, SW, 0, 0, 2, "abort_memadr2");
        step(0, SW, 0, 0, 5, "abort_memwr2");
        step(0, SW, 0, 0, 0, "abort_final_fetch");

        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/unidade_controle_multiciclo.md
# unidade_controle_multiciclo

Multi-cycle control unit for the MIPS-subset datapath. It drives the `ULA_control` select of the `ULA` stage and consumes its `Zero` flag for branch resolution. It sequences fetch, decode, execute, memory and write-back through a Moore state machine, and produces every datapath enable and mux select. It contains the ALU decoder that maps opcode and funct to the 3-bit `ULA_control` code.

## Interface
- No parameters.
- `clk` input 1: single clock; all state updates on rising edge.
- `reset` input 1: synchronous, active-high.
- `opcode` input 6: instruction bits [31:26] from the instruction register.
- `funct` input 6: instruction bits [5:0] from the instruction register.
- `Zero` input 1: `ULA` zero flag.
- `pc_en` output 1: PC load enable, equal to `pc_write | (branch & Zero)`.
- `i_or_d` output 1: memory address select; 0 = PC, 1 = ULA result register.
- `mem_write` output 1: data memory write strobe.
- `ir_write` output 1: instruction register load.
- `reg_dst` output 1: destination select; 0 = rt, 1 = rd.
- `mem_to_reg` output 1: write-back data select; 0 = ULA result, 1 = memory data.
- `reg_write` output 1: register file write enable.
- `ula_src_a` output 1: operand A select; 0 = PC, 1 = register A.
- `ula_src_b` output 2: operand B select; 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left 2.
- `pc_src` output 2: next-PC select; 00 = ULA result, 01 = ULA result register, 10 = jump target.
- `ULA_control` output 3: `ULA` operation code.
- `estado` output 4: current state encoding, for debug.
- `opcode_invalido` output 1: single-cycle pulse on an unsupported opcode or funct.

## Operation
- State encodings:
  - FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4, MEMWR = 5.
  - EXECUTE = 6, ALUWB = 7, BRANCH = 8, ADDIEXEC = 9, ADDIWB = 10, JUMP = 11.
- Unused encodings 12–15 go to FETCH on the next edge.
- Transitions:
  - FETCH → DECODE.
  - DECODE → MEMADR on lw (100011) or sw (101011).
  - DECODE → EXECUTE on R-type (000000).
  - DECODE → BRANCH on beq (000100).
  - DECODE → ADDIEXEC on addi (001000).
  - DECODE → JUMP on j (000010).
  - DECODE → FETCH on any other opcode, with `opcode_invalido` = 1.
  - MEMADR → MEMREAD on lw; MEMADR → MEMWR on sw.
  - MEMREAD → MEMWB.
  - EXECUTE → ALUWB if funct is valid; otherwise EXECUTE → FETCH with `opcode_invalido` = 1.
  - ADDIEXEC → ADDIWB.
  - MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH and JUMP all → FETCH.
- Outputs are a Moore decode of the state. Any signal not listed for a state is 0, and `ULA_control` defaults to 010.
  - FETCH: `ir_write` = 1, `pc_write` = 1, `ula_src_b` = 01, `ULA_control` = 010.
  - DECODE: `ula_src_b` = 11, `ULA_control` = 010 (branch target precompute).
  - MEMADR and ADDIEXEC: `ula_src_a` = 1, `ula_src_b` = 10, `ULA_control` = 010.
  - MEMREAD: `i_or_d` = 1.
  - MEMWR: `i_or_d` = 1, `mem_write` = 1.
  - MEMWB: `mem_to_reg` = 1, `reg_write` = 1.
  - EXECUTE: `ula_src_a` = 1, `ula_src_b` = 00, `ULA_control` decoded from funct (see below).
  - ALUWB: `reg_dst` = 1, `reg_write` = 1.
  - ADDIWB: `reg_write` = 1.
  - BRANCH: `ula_src_a` = 1, `ula_src_b` = 00, `ULA_control` = 110, `pc_src` = 01, internal `branch` = 1.
  - JUMP: `pc_src` = 10, `pc_write` = 1.
- Funct decode in EXECUTE:
  - 100000 (add) → 010.
  - 100010 (sub) → 110.
  - 100100 (and) → 000.
  - 100101 (or) → 001.
  - 101010 (slt) → 111.
  - 100111 (nor) → 100.
  - Any other funct → 010 and counts as invalid.
- `opcode` is examined only in DECODE and MEMADR; `funct` only in EXECUTE. Changes to either input in other states have no effect.

## Timing
- Reset: while `reset` = 1, the next state is FETCH and every output is forced to 0, except `ULA_control` = 010 and `estado` = 0. The first cycle after release is FETCH with its normal outputs.
- Reset asserted mid-instruction aborts it on the next edge, with no further write strobes.
- Cycles per instruction, FETCH through final state inclusive:
  - lw 5; sw 4; R-type 4; addi 4; beq 3; j 3.
  - Invalid opcode 2; invalid funct 3.
- `pc_en` is combinational from state and `Zero` in the same cycle. In BRANCH, `Zero` = 1 gives `pc_en` = 1 and `Zero` = 0 gives `pc_en` = 0.
- `opcode_invalido` is asserted during the DECODE or EXECUTE cycle that detects the invalid code; it is combinational from state, `opcode` and `funct`.

## Configuration
- `ADDI_EN` defined: addi is supported, and the ADDIEXEC and ADDIWB states exist.
- `ADDI_EN` undefined: opcode 001000 is handled as invalid (DECODE → FETCH with `opcode_invalido` pulse). Encodings 9 and 10 become unused and recover to FETCH.

## Test plan
- Reset for 2 cycles, then release → `estado` = 0, `ir_write` = 1, `pc_en` = 1 on the first cycle after release, with `ULA_control` = 010.
- opcode 100011 → `estado` sequence 0, 1, 2, 3, 4. `reg_write` = 1 and `mem_to_reg` = 1 occur only in state 4; `mem_write` stays 0 throughout.
- opcode 000000 with each of the six funct codes → `ULA_control` in EXECUTE equals 010, 110, 000, 001, 111, 100 respectively. Funct 000000 → `opcode_invalido` pulse, return to FETCH, `reg_write` never asserted.
- opcode 000100 in BRANCH with `Zero` = 1 → `pc_en` = 1 and `pc_src` = 01. Repeated with `Zero` = 0 → `pc_en` = 0 and the next state is FETCH.
- opcode 101011 with `reset` raised during MEMADR → no `mem_write` pulse, and `estado` = 0 one cycle later.
- opcode 001000 → states 0, 1, 9, 10 with `reg_write` = 1 and `reg_dst` = 0 in state 10. Built without `ADDI_EN` → states 0, 1 then 0, with an `opcode_invalido` pulse in DECODE.
